// File: rtl/xoodyak_job_sched_pkg.sv
// rtl/xoodyak_job_sched_pkg.sv - shared widths, FSM states and job record for the xoodyak job scheduler
package xoodyak_sched_pkg;

   localparam int TEXT_W = 192;
   localparam int BLK_W  = 128;
   localparam int ID_W   = 3;     // wide enough for up to 8 requesters

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      RUN,
      RESP
   } state_t;

   typedef struct packed {
      logic              opmode;
      logic [TEXT_W-1:0] text;
      logic [BLK_W-1:0]  nonce;
      logic [BLK_W-1:0]  assodata;
      logic [BLK_W-1:0]  key;
      logic [BLK_W-1:0]  tag;
      logic [ID_W-1:0]   id;
   } job_t;

endpackage

// File: rtl/xoodyak_job_sched_if.sv
// rtl/xoodyak_job_sched_if.sv - requester, core and response signals of the job scheduler
// slave modport: scheduler side (takes requests and core results, drives grants, core operands, response)
// master modport: environment side (requesters, xoodyak core, response consumer)
interface xoodyak_job_sched_if
   import xoodyak_sched_pkg::*;
#(
   parameter int NREQ = 2
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_opmode;
   logic [NREQ*TEXT_W-1:0] req_text;
   logic [NREQ*BLK_W-1:0]  req_nonce;
   logic [NREQ*BLK_W-1:0]  req_assodata;
   logic [NREQ*BLK_W-1:0]  req_key;
   logic [NREQ*BLK_W-1:0]  req_tag;
   logic [NREQ-1:0]        req_grant;

   logic                   core_start;
   logic [TEXT_W-1:0]      core_textin;
   logic [BLK_W-1:0]       core_nonce;
   logic [BLK_W-1:0]       core_assodata;
   logic [BLK_W-1:0]       core_key;
   logic [BLK_W-1:0]       core_verif;
   logic                   core_opmode;
   logic [TEXT_W-1:0]      core_textout;
   logic [BLK_W-1:0]       core_authdata;
   logic                   core_sqzdone;
   logic                   core_verify;

   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [IDW-1:0]         rsp_id;
   logic [TEXT_W-1:0]      rsp_text;
   logic [BLK_W-1:0]       rsp_auth;
   logic                   rsp_verify;
   logic                   rsp_err;
   logic                   busy;

   modport slave (
      input  req_valid, req_opmode, req_text, req_nonce, req_assodata, req_key, req_tag,
      output req_grant,
      output core_start, core_textin, core_nonce, core_assodata, core_key, core_verif, core_opmode,
      input  core_textout, core_authdata, core_sqzdone, core_verify,
      output rsp_valid, rsp_id, rsp_text, rsp_auth, rsp_verify, rsp_err, busy,
      input  rsp_ready
   );

   modport master (
      output req_valid, req_opmode, req_text, req_nonce, req_assodata, req_key, req_tag,
      input  req_grant,
      input  core_start, core_textin, core_nonce, core_assodata, core_key, core_verif, core_opmode,
      output core_textout, core_authdata, core_sqzdone, core_verify,
      input  rsp_valid, rsp_id, rsp_text, rsp_auth, rsp_verify, rsp_err, busy,
      output rsp_ready
   );

endinterface

// File: rtl/xoodyak_job_sched_rr_arbiter.sv
// rtl/xoodyak_job_sched_rr_arbiter.sv - combinational round-robin pick of the first request at/after a pointer
// req_i: request vector, ptr_i: highest-priority port
// grant_o: one-hot winner, next_ptr_o: port after the winner (mod N), any_o: some request present
module rr_arbiter #(
   parameter int N  = 2,
   parameter int PW = 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic [PW-1:0] next_ptr_o,
   output logic          any_o
);

   int   idx;
   logic found;

   always_comb begin
      grant_o    = '0;
      next_ptr_o = ptr_i;
      found      = 1'b0;
      idx        = 0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(ptr_i) + i) % N;
         if (!found && req_i[idx]) begin
            found        = 1'b1;
            grant_o[idx] = 1'b1;
            next_ptr_o   = PW'((idx + 1) % N);
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/xoodyak_job_sched.sv
// rtl/xoodyak_job_sched.sv - shares one xoodyak AEAD core between NREQ requesters, one job at a time
// eph1/reset: clock and asynchronous active-high reset
// bus (slave): per-port requests and one-hot grant, latched core operands with start pulse,
//              core results in, tagged response out with valid/ready, busy
module xoodyak_job_sched
   import xoodyak_sched_pkg::*;
#(
   parameter int NREQ        = 2,
   parameter int TIMEOUT_CYC = 255
) (
   input logic                eph1,
   input logic                reset,
   xoodyak_job_sched_if.slave bus
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYC);

   state_t            state_q;
   job_t              job_q;
   job_t              job_d;
   logic [PW-1:0]     ptr_q;
   logic [PW-1:0]     arb_next_ptr;
   logic [NREQ-1:0]   arb_grant;
   logic              arb_any;
   logic [TW-1:0]     timer_q;
   logic              core_start_q;
   logic              rsp_valid_q;
   logic              rsp_verify_q;
   logic              rsp_err_q;
   logic [TEXT_W-1:0] rsp_text_q;
   logic [BLK_W-1:0]  rsp_auth_q;

   rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
      .req_i      (bus.req_valid),
      .ptr_i      (ptr_q),
      .grant_o    (arb_grant),
      .next_ptr_o (arb_next_ptr),
      .any_o      (arb_any)
   );

   // Operand mux for the winning port.
   always_comb begin
      job_d = '0;
      for (int p = 0; p < NREQ; p++) begin
         if (arb_grant[p]) begin
            job_d.opmode   = bus.req_opmode[p];
            job_d.text     = bus.req_text[p*TEXT_W +: TEXT_W];
            job_d.nonce    = bus.req_nonce[p*BLK_W +: BLK_W];
            job_d.assodata = bus.req_assodata[p*BLK_W +: BLK_W];
            job_d.key      = bus.req_key[p*BLK_W +: BLK_W];
            job_d.tag      = bus.req_tag[p*BLK_W +: BLK_W];
            job_d.id       = ID_W'(p);
         end
      end
   end

   always_ff @(posedge eph1 or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         job_q        <= '0;
         ptr_q        <= '0;
         timer_q      <= '0;
         core_start_q <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_verify_q <= 1'b0;
         rsp_err_q    <= 1'b0;
         rsp_text_q   <= '0;
         rsp_auth_q   <= '0;
      end else begin
         core_start_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (arb_any) begin
                  job_q        <= job_d;
                  ptr_q        <= arb_next_ptr;
                  core_start_q <= 1'b1;
                  state_q      <= LAUNCH;
               end
            end
            LAUNCH: begin
               timer_q <= '0;
               state_q <= RUN;
            end
            RUN: begin
               // sqzdone is tested first so a result landing on the timeout cycle is kept.
               if (bus.core_sqzdone) begin
                  rsp_text_q   <= bus.core_textout;
                  rsp_auth_q   <= bus.core_authdata;
                  rsp_verify_q <= job_q.opmode ? bus.core_verify : 1'b1;
                  rsp_err_q    <= 1'b0;
                  rsp_valid_q  <= 1'b1;
                  state_q      <= RESP;
               end else if (timer_q == TIMER_MAX) begin
                  rsp_text_q   <= '0;
                  rsp_auth_q   <= '0;
                  rsp_verify_q <= 1'b0;
                  rsp_err_q    <= 1'b1;
                  rsp_valid_q  <= 1'b1;
                  state_q      <= RESP;
               end else begin
                  // RUN is left at TIMER_MAX, so the counter can never wrap.
                  timer_q <= timer_q + 1'b1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // The grant is combinational from IDLE; masking with reset keeps it low while reset is held.
   assign bus.req_grant     = (state_q == IDLE && !reset) ? arb_grant : '0;
   assign bus.core_start    = core_start_q;
   assign bus.core_textin   = job_q.text;
   assign bus.core_nonce    = job_q.nonce;
   assign bus.core_assodata = job_q.assodata;
   assign bus.core_key      = job_q.key;
   assign bus.core_verif    = job_q.tag;
   assign bus.core_opmode   = job_q.opmode;
   assign bus.rsp_valid     = rsp_valid_q;
   assign bus.rsp_id        = job_q.id[PW-1:0];
   assign bus.rsp_text      = rsp_text_q;
   assign bus.rsp_auth      = rsp_auth_q;
   assign bus.rsp_verify    = rsp_verify_q;
   assign bus.rsp_err       = rsp_err_q;
   assign bus.busy          = (state_q != IDLE);

endmodule

// File: tb/tb_xoodyak_job_sched.sv
// tb/tb_xoodyak_job_sched.sv - directed scoreboard bench for xoodyak_job_sched with a behavioural core
module tb_xoodyak_job_sched;

   localparam int TW = 192;
   localparam int BW = 128;
   localparam int TO = 8;

   typedef struct {
      logic [2:0]    id;
      logic [TW-1:0] text;
      logic [BW-1:0] auth;
      logic          verify;
      logic          err;
   } exp_t;

   logic eph1;
   logic reset;
   int   checks   = 0;
   int   failures = 0;
   int   jobs     = 0;
   int   starts   = 0;
   int   overlap  = 0;
   bit   inflight = 0;
   int   core_lat  = 3;
   bit   core_dead = 0;
   int   cnt;
   bit   armed;
   int   lat_n;
   exp_t sb[$];
   logic [TW-1:0] m_ks, m_pt;

   logic [TW-1:0] pt0 = 192'h4d4e4f505152535455565758_4142434445464748494a4b4c;
   logic [TW-1:0] pt1 = 192'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978;
   logic [BW-1:0] key0 = 128'h38393a3b3c3d3e3f3031323334353637;
   logic [BW-1:0] non0 = 128'h494a4b4c4d4e4f404142434445464748;
   logic [BW-1:0] ad0  = 128'h696a6b6c6d6e6f606162636465666768;
   logic [TW-1:0] ct0;
   logic [BW-1:0] tag0;

   xoodyak_job_sched_if #(.NREQ(2)) bus ();

   xoodyak_job_sched #(.NREQ(2), .TIMEOUT_CYC(TO)) dut (
      .eph1  (eph1),
      .reset (reset),
      .bus   (bus)
   );

   initial eph1 = 1'b0;
   always #5 eph1 = ~eph1;

   // Toy AEAD standing in for xoodyak: keystream xor and a keyed tag over the plaintext.
   function automatic logic [TW-1:0] ksf(input logic [BW-1:0] k, input logic [BW-1:0] n, input logic [BW-1:0] a);
      logic [BW-1:0] t;
      t = a ^ n;
      return {k ^ {n[63:0], n[127:64]}, t[63:0] ^ t[127:64]};
   endfunction

   function automatic logic [BW-1:0] tagf(input logic [TW-1:0] pt, input logic [BW-1:0] k,
                                           input logic [BW-1:0] n, input logic [BW-1:0] a);
      return pt[127:0] ^ {pt[191:128], pt[191:128]} ^ {k[63:0], k[127:64]} ^ n ^ ~a;
   endfunction

   // Behavioural core: sqzdone comes core_lat cycles after the start edge, computed from live operands.
   always @(posedge eph1 or posedge reset) begin
      if (reset) begin
         armed             <= 1'b0;
         cnt               <= 0;
         bus.core_sqzdone  <= 1'b0;
         bus.core_textout  <= '0;
         bus.core_authdata <= '0;
         bus.core_verify   <= 1'b0;
      end else begin
         bus.core_sqzdone <= 1'b0;
         if (bus.core_start) begin
            armed <= !core_dead;
            cnt   <= core_lat;
         end else if (armed) begin
            if (cnt <= 1) begin
               armed            <= 1'b0;
               bus.core_sqzdone <= 1'b1;
               m_ks = ksf(bus.core_key, bus.core_nonce, bus.core_assodata);
               m_pt = bus.core_opmode ? (bus.core_textin ^ m_ks) : bus.core_textin;
               bus.core_textout  <= bus.core_textin ^ m_ks;
               bus.core_authdata <= tagf(m_pt, bus.core_key, bus.core_nonce, bus.core_assodata);
               bus.core_verify   <= bus.core_opmode &&
                                    (tagf(m_pt, bus.core_key, bus.core_nonce, bus.core_assodata) == bus.core_verif);
            end else begin
               cnt <= cnt - 1;
            end
         end
      end
   end

   // Start monitor: counts core_start pulses and any start issued while a job is unanswered.
   always @(posedge eph1 or posedge reset) begin
      if (reset) begin
         inflight = 1'b0;
      end else begin
         if (bus.rsp_valid && bus.rsp_ready) inflight = 1'b0;
         if (bus.core_start) begin
            starts++;
            if (inflight) overlap++;
            inflight = 1'b1;
         end
      end
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_port(input int p, input logic opm, input logic [TW-1:0] txt,
                           input logic [BW-1:0] tg);
      bus.req_opmode[p]              = opm;
      bus.req_text[p*TW +: TW]       = txt;
      bus.req_nonce[p*BW +: BW]      = non0;
      bus.req_assodata[p*BW +: BW]   = ad0;
      bus.req_key[p*BW +: BW]        = key0;
      bus.req_tag[p*BW +: BW]        = tg;
   endtask

   task automatic push_enc(input int id, input logic [TW-1:0] pt);
      exp_t e;
      e.id = 3'(id); e.text = pt ^ ksf(key0, non0, ad0); e.auth = tagf(pt, key0, non0, ad0);
      e.verify = 1'b1; e.err = 1'b0;
      sb.push_back(e);
   endtask

   task automatic push_dec(input int id, input logic [TW-1:0] ct, input logic [BW-1:0] tg);
      exp_t e;
      e.id = 3'(id); e.text = ct ^ ksf(key0, non0, ad0); e.auth = tagf(e.text, key0, non0, ad0);
      e.verify = (e.auth == tg); e.err = 1'b0;
      sb.push_back(e);
   endtask

   task automatic push_err(input int id);
      exp_t e;
      e.id = 3'(id); e.text = '0; e.auth = '0; e.verify = 1'b0; e.err = 1'b1;
      sb.push_back(e);
   endtask

   // Waits (bounded) for a grant, checks it, then checks the start pulse in LAUNCH.
   task automatic start_job(input int p, input logic [1:0] exp_grant, input bit drop, input string tag);
      int n;
      n = 0;
      #1;
      while (bus.req_grant == 2'b00 && n < 50) begin
         @(negedge eph1); #1; n++;
      end
      chk({tag, "_grant"}, bus.req_grant, exp_grant);
      jobs++;
      @(negedge eph1);
      if (drop) bus.req_valid[p] = 1'b0;
      chk({tag, "_start"}, bus.core_start, 1'b1);
      chk({tag, "_busy"}, bus.busy, 1'b1);
   endtask

   // Waits (bounded) for a response, compares it against the scoreboard head for hold+1 cycles, then accepts it.
   task automatic wait_rsp(input int hold, input string tag);
      exp_t e;
      int   n;
      n = 0;
      while (!bus.rsp_valid && n < 60) begin
         @(negedge eph1); n++;
      end
      chk({tag, "_rsp_valid"}, bus.rsp_valid, 1'b1);
      checks++;
      assert (sb.size() > 0) else begin
         failures++;
         $error("FAIL %s_sb observed=empty expected=entry", tag);
      end
      if (sb.size() == 0) return;
      e = sb.pop_front();
      for (int c = 0; c <= hold; c++) begin
         if (c > 0) @(negedge eph1);
         chk({tag, "_id"},     bus.rsp_id,     e.id[0]);
         chk({tag, "_text"},   bus.rsp_text,   e.text);
         chk({tag, "_auth"},   bus.rsp_auth,   e.auth);
         chk({tag, "_verify"}, bus.rsp_verify, e.verify);
         chk({tag, "_err"},    bus.rsp_err,    e.err);
         chk({tag, "_nogrant"}, bus.req_grant, 2'b00);
         if (c > 0) chk({tag, "_held"}, bus.rsp_valid, 1'b1);
      end
      bus.rsp_ready = 1'b1;
      @(negedge eph1);
      bus.rsp_ready = 1'b0;
      chk({tag, "_valid_drop"}, bus.rsp_valid, 1'b0);
      chk({tag, "_idle"}, bus.busy, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      reset            = 1'b1;
      bus.req_valid    = '0;
      bus.req_opmode   = '0;
      bus.req_text     = '0;
      bus.req_nonce    = '0;
      bus.req_assodata = '0;
      bus.req_key      = '0;
      bus.req_tag      = '0;
      bus.rsp_ready    = 1'b0;
      ct0  = pt0 ^ ksf(key0, non0, ad0);
      tag0 = tagf(pt0, key0, non0, ad0);
      repeat (2) @(negedge eph1);
      reset = 1'b0;
      #1;
      chk("rst_busy",   bus.busy,        1'b0);
      chk("rst_valid",  bus.rsp_valid,   1'b0);
      chk("rst_start",  bus.core_start,  1'b0);
      chk("rst_grant",  bus.req_grant,   2'b00);
      chk("rst_textin", bus.core_textin, 192'h0);
      chk("rst_key",    bus.core_key,    128'h0);
      chk("rst_text",   bus.rsp_text,    192'h0);
      chk("rst_err",    bus.rsp_err,     1'b0);
      @(negedge eph1);

      // Port0 encrypt of the reference vector.
      set_port(0, 1'b0, pt0, '0);
      bus.req_valid[0] = 1'b1;
      push_enc(0, pt0);
      start_job(0, 2'b01, 1'b1, "enc0");
      wait_rsp(0, "enc0");

      // Port1 decrypt of port0's ciphertext and tag, then with tag bit0 flipped.
      set_port(1, 1'b1, ct0, tag0);
      bus.req_valid[1] = 1'b1;
      push_dec(1, ct0, tag0);
      start_job(1, 2'b10, 1'b1, "dec1");
      wait_rsp(0, "dec1");
      set_port(1, 1'b1, ct0, tag0 ^ 128'h1);
      bus.req_valid[1] = 1'b1;
      push_dec(1, ct0, tag0 ^ 128'h1);
      start_job(1, 2'b10, 1'b1, "decbad");
      wait_rsp(0, "decbad");

      // Both ports requesting continuously: strict alternation, one response stalled 20 cycles.
      set_port(0, 1'b0, pt0, '0);
      set_port(1, 1'b0, pt1, '0);
      bus.req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         if (k % 2 == 0) push_enc(0, pt0);
         else            push_enc(1, pt1);
         start_job(k % 2, (k % 2 == 0) ? 2'b01 : 2'b10, 1'b0, "alt");
         wait_rsp((k == 1) ? 20 : 0, "alt");
      end
      bus.req_valid = 2'b00;

      // Dead core: abort after TO timer increments with error.
      core_dead = 1'b1;
      bus.req_valid[0] = 1'b1;
      push_err(0);
      start_job(0, 2'b01, 1'b1, "tmo");
      lat_n = 0;
      while (!bus.rsp_valid && lat_n < 40) begin
         @(negedge eph1); lat_n++;
      end
      chk("tmo_latency", 32'(lat_n), 32'(TO + 2));
      wait_rsp(0, "tmo");
      core_dead = 1'b0;

      // sqzdone on the timeout cycle wins.
      core_lat = TO;
      bus.req_valid[0] = 1'b1;
      push_enc(0, pt0);
      start_job(0, 2'b01, 1'b1, "edge");
      lat_n = 0;
      while (!bus.rsp_valid && lat_n < 40) begin
         @(negedge eph1); lat_n++;
      end
      chk("edge_latency", 32'(lat_n), 32'(TO + 2));
      wait_rsp(0, "edge");

      // sqzdone one cycle late: error, and the late sqzdone in RESP must not disturb fields.
      core_lat = TO + 1;
      bus.req_valid[0] = 1'b1;
      push_err(0);
      start_job(0, 2'b01, 1'b1, "late");
      wait_rsp(3, "late");
      core_lat = 3;

      // Async reset mid-RUN with pointer at 1; afterwards port0 must win again.
      core_dead = 1'b1;
      set_port(1, 1'b0, pt1, '0);
      bus.req_valid[0] = 1'b1;
      start_job(0, 2'b01, 1'b1, "rst_run");
      repeat (3) @(negedge eph1);
      bus.req_valid = 2'b11;
      #2;
      reset = 1'b1;
      #1;
      chk("arst_busy",   bus.busy,        1'b0);
      chk("arst_grant",  bus.req_grant,   2'b00);
      chk("arst_textin", bus.core_textin, 192'h0);
      chk("arst_key",    bus.core_key,    128'h0);
      chk("arst_opmode", bus.core_opmode, 1'b0);
      chk("arst_valid",  bus.rsp_valid,   1'b0);
      @(negedge eph1);
      reset     = 1'b0;
      core_dead = 1'b0;
      push_enc(0, pt0);
      start_job(0, 2'b01, 1'b1, "post0");
      wait_rsp(0, "post0");
      push_enc(1, pt1);
      start_job(1, 2'b10, 1'b1, "post1");
      wait_rsp(0, "post1");

      repeat (3) @(negedge eph1);
      chk("start_count", 32'(starts), 32'(jobs));
      chk("no_overlap",  32'(overlap), 32'd0);
      chk("sb_drained",  32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
